// File: rtl/md_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// md_sequencer: multi-cycle multiply/divide unit with HI/LO registers and E-stage flush.
// Revision: 1.0
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  start,
  input  logic        MDaddress,
  input  logic        MD_write_enable,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] md_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MULT  = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic               pend_valid_q, pend_valid_d;

  logic        w_start_valid;
  logic [63:0] w_mul_u, w_mul_s;
  logic [31:0] w_divu_q, w_divu_r;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_abs, w_b_abs, w_divs_qm, w_divs_rm, w_divs_q, w_divs_r;

  assign w_start_valid = (start == OP_MULTU) || (start == OP_MULT) ||
                         (start == OP_DIVU)  || (start == OP_DIV);

  // Signed product taken as the low 64 bits of the sign-extended operands' product.
  assign w_mul_u = {32'b0, rs_data} * {32'b0, rt_data};
  assign w_mul_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};

  assign w_divu_q = rs_data / rt_data;
  assign w_divu_r = rs_data % rt_data;

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_a_neg   = rs_data[31];
  assign w_b_neg   = rt_data[31];
  assign w_a_abs   = w_a_neg ? (32'd0 - rs_data) : rs_data;
  assign w_b_abs   = w_b_neg ? (32'd0 - rt_data) : rt_data;
  assign w_divs_qm = w_a_abs / w_b_abs;
  assign w_divs_rm = w_a_abs % w_b_abs;
  assign w_divs_q  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_divs_qm) : w_divs_qm;
  assign w_divs_r  = w_a_neg ? (32'd0 - w_divs_rm) : w_divs_rm;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;
    case (state_q)
      S_IDLE: begin
        if (!req) begin
          if (w_start_valid) begin
            state_d      = S_RUN;
            busy_d       = 1'b1;
            pend_valid_d = 1'b1;
            cnt_d        = CNT_W'(MULT_CYCLES);
            case (start)
              OP_MULTU: {pend_hi_d, pend_lo_d} = w_mul_u;
              OP_MULT:  {pend_hi_d, pend_lo_d} = w_mul_s;
              OP_DIVU: begin
                pend_hi_d    = w_divu_r;
                pend_lo_d    = w_divu_q;
                pend_valid_d = |rt_data;
                cnt_d        = CNT_W'(DIV_CYCLES);
              end
              default: begin
                pend_hi_d    = w_divs_r;
                pend_lo_d    = w_divs_q;
                pend_valid_d = |rt_data;
                cnt_d        = CNT_W'(DIV_CYCLES);
              end
            endcase
          end else if (MD_write_enable) begin
            if (MDaddress) hi_d = rs_data;
            else           lo_d = rs_data;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (pend_valid_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          pend_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign busy   = busy_q;
  assign md_out = MDaddress ? hi_q : lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// tb_md_sequencer: directed and randomized checks of md_sequencer against a behavioural HI/LO model.
// Revision: 1.0
module tb_md_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, req, MDaddress, MD_write_enable;
  logic [2:0]  start;
  logic [31:0] rs_data, rt_data;
  logic        busy;
  logic [31:0] md_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .MDaddress(MDaddress),
    .MD_write_enable(MD_write_enable), .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .md_out(md_out)
  );

  // The stimulus must never issue md traffic while the unit is busy.
  always @(posedge clk) begin
    if (!reset && busy === 1'b1 && !req && (start != 3'd0 || MD_write_enable)) begin
      errors++;
      $display("FAIL stall_rule: start=%0d we=%0b issued while busy", start, MD_write_enable);
    end
  end

  // Behavioural result: {valid, hi, lo}
  function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ref_op = '0;
    case (op)
      3'd1: begin p = {32'b0, a} * {32'b0, b}; ref_op = {1'b1, p}; end
      3'd2: begin p = sa * sb; ref_op = {1'b1, p}; end
      3'd3: if (b != 0) ref_op = {1'b1, a % b, a / b};
      3'd4: if (b != 0) begin q = sa / sb; r = sa % sb; ref_op = {1'b1, r[31:0], q[31:0]}; end
      default: ref_op = '0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op);
    return (op <= 3'd2) ? MULT_N : DIV_N;
  endfunction

  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] res;
    res = ref_op(op, a, b);
    if (res[64]) {m_hi, m_lo} = res[63:0];
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    MDaddress = 1'b1; #1 hi = md_out;
    MDaddress = 1'b0; #1 lo = md_out;
  endtask

  // Called at a negedge with busy low; returns at the negedge of the first idle cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int nbusy);
    start = op; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 3'd0; rs_data = $urandom; rt_data = $urandom;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 40) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic mt_write(input logic sel, input logic [31:0] data, input logic rq);
    MD_write_enable = 1'b1; MDaddress = sel; rs_data = data; req = rq;
    @(negedge clk);
    MD_write_enable = 1'b0; req = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] hi, lo;
    reset = 1'b1; req = 1'b0; start = 3'd0; MDaddress = 1'b0; MD_write_enable = 1'b0;
    rs_data = '0; rt_data = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); end
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int n; logic [31:0] hi, lo;
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, n);
    checks++;
    if (n !== MULT_N) begin errors++; $display("FAIL mult_busy: got %0d cycles want %0d", n, MULT_N); end
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_result: got %h/%h want ffffffff/fffffffa", hi, lo); end
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFA;
  endtask

  task automatic test_multu_div;
    int n; logic [31:0] hi, lo;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    read_hilo(hi, lo);
    checks++;
    if (n !== MULT_N || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++; $display("FAIL multu: got n=%0d %h/%h want n=%0d fffffffe/00000001", n, hi, lo, MULT_N);
    end
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, n);
    checks++;
    if (n !== DIV_N) begin errors++; $display("FAIL div_busy: got %0d cycles want %0d", n, DIV_N); end
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg7_2: got %h/%h want ffffffff/fffffffd", hi, lo); end
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFD;
  endtask

  task automatic test_div_edge;
    int n; logic [31:0] hi, lo;
    mt_write(1'b1, 32'h11, 1'b0);
    mt_write(1'b0, 32'h22, 1'b0);
    run_op(3'd3, 32'd7, 32'd0, n);
    read_hilo(hi, lo);
    checks++;
    if (n !== DIV_N || hi !== 32'h11 || lo !== 32'h22) begin
      errors++; $display("FAIL divu_by_zero: got n=%0d %h/%h want n=%0d 00000011/00000022", n, hi, lo, DIV_N);
    end
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, n);
    read_hilo(hi, lo);
    checks++;
    if (n !== DIV_N || hi !== 32'h0 || lo !== 32'h8000_0000) begin
      errors++; $display("FAIL div_overflow: got n=%0d %h/%h want n=%0d 00000000/80000000", n, hi, lo, DIV_N);
    end
    m_hi = 32'h0; m_lo = 32'h8000_0000;
  endtask

  task automatic test_flush;
    logic [31:0] hi, lo;
    start = 3'd1; req = 1'b1; rs_data = 32'h1234; rt_data = 32'h5678;
    @(negedge clk);
    start = 3'd0; req = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b want 0", busy); end
    @(negedge clk);
    read_hilo(hi, lo);
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL flush_start_hilo: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
    mt_write(1'b1, 32'hCAFE_F00D, 1'b1);
    read_hilo(hi, lo);
    checks++;
    if (hi !== m_hi) begin errors++; $display("FAIL flush_mthi: got %h want %h", hi, m_hi); end
  endtask

  task automatic test_mt;
    mt_write(1'b1, 32'hDEAD_BEEF, 1'b0);
    MDaddress = 1'b1; #1;
    checks++;
    if (md_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi: got %h want deadbeef", md_out); end
    mt_write(1'b0, 32'h1234_5678, 1'b0);
    MDaddress = 1'b0; #1;
    checks++;
    if (md_out !== 32'h1234_5678) begin errors++; $display("FAIL mtlo: got %h want 12345678", md_out); end
    MDaddress = 1'b1; #1;
    checks++;
    if (md_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_kept: got %h want deadbeef", md_out); end
    m_hi = 32'hDEAD_BEEF; m_lo = 32'h1234_5678;
  endtask

  task automatic test_start_wins_req_midrun;
    int n; logic [31:0] hi, lo;
    start = 3'd2; MD_write_enable = 1'b1; MDaddress = 1'b1; rs_data = 32'd5; rt_data = 32'd7;
    @(negedge clk);
    start = 3'd0; MD_write_enable = 1'b0;
    MDaddress = 1'b1; #1;
    checks++;
    if (md_out !== m_hi) begin errors++; $display("FAIL start_wins: got hi=%h want %h", md_out, m_hi); end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      req = (n == 1 || n == 2);
      n++;
      @(negedge clk);
    end
    req = 1'b0;
    read_hilo(hi, lo);
    checks++;
    if (n !== MULT_N || hi !== 32'd0 || lo !== 32'd35) begin
      errors++; $display("FAIL req_midrun: got n=%0d %h/%h want n=%0d 00000000/00000023", n, hi, lo, MULT_N);
    end
    m_hi = 32'd0; m_lo = 32'd35;
  endtask

  task automatic test_back_to_back;
    int n; logic [31:0] hi, lo, a, b;
    logic [2:0] ops [3] = '{3'd3, 3'd2, 3'd4};
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom_range(1, 1000);
      run_op(ops[i], a, b, n);
      model_apply(ops[i], a, b);
      read_hilo(hi, lo);
      checks++;
      if (n !== ref_lat(ops[i]) || hi !== m_hi || lo !== m_lo) begin
        errors++; $display("FAIL back_to_back[%0d]: got n=%0d %h/%h want n=%0d %h/%h", i, n, hi, lo, ref_lat(ops[i]), m_hi, m_lo);
      end
    end
  endtask

  task automatic test_random;
    int n; logic [31:0] hi, lo, a, b; logic [2:0] op; logic sel;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        sel = 1'($urandom_range(0, 1)); a = $urandom;
        mt_write(sel, a, 1'b0);
        if (sel) m_hi = a; else m_lo = a;
        n = 0; op = 3'd0;
      end else begin
        op = 3'($urandom_range(1, 4));
        a = $urandom; b = $urandom;
        if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 9);
        if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
        run_op(op, a, b, n);
        model_apply(op, a, b);
      end
      read_hilo(hi, lo);
      checks++;
      if ((op != 3'd0 && n !== ref_lat(op)) || hi !== m_hi || lo !== m_lo) begin
        errors++; $display("FAIL random[%0d] op=%0d: got n=%0d %h/%h want %h/%h", i, op, n, hi, lo, m_hi, m_lo);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_midrun;
    logic [31:0] hi, lo;
    start = 3'd4; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    read_hilo(hi, lo);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_midrun: got busy=%b %h/%h want 0 00000000/00000000", busy, hi, lo);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      read_hilo(hi, lo);
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        errors++; $display("FAIL late_commit[%0d]: got busy=%b %h/%h want 0 00000000/00000000", i, busy, hi, lo);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu_div;
    test_div_edge;
    test_flush;
    test_mt;
    test_start_wins_req_midrun;
    test_back_to_back;
    test_random;
    test_reset_midrun;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the Execute stage. It accepts the E-stage `start` code and operands, and computes the 64-bit product or the quotient/remainder. It holds `busy` for a fixed latency, then commits the result to HI/LO. It also serves `mthi`/`mtlo` writes and `mfhi`/`mflo` reads, and honours the exception flush request so a cancelled instruction never alters HI/LO.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk  in  1`: clock. Everything is rising-edge.
- `reset  in  1`: synchronous, active-high reset.
- `req  in  1`: exception/interrupt flush for the instruction currently in E. When high, `start` and `MD_write_enable` are ignored this cycle.
- `start  in  3`: operation code. 001 multu, 010 mult, 011 divu, 100 div. 000 and 101–111 mean none.
- `MDaddress  in  1`: selects HI when 1, LO when 0, for both read and write.
- `MD_write_enable  in  1`: mthi/mtlo write of `rs_data` into the selected register.
- `rs_data  in  32`: operand A / dividend / mt write data.
- `rt_data  in  32`: operand B / divisor.
- `busy  out  1`: operation in flight. Registered.
- `md_out  out  32`: HI if `MDaddress` is 1, else LO. Combinational from the registers.

## Operation
- States: IDLE, RUN. Internal state is a down-counter `cnt` (4 bits minimum), pending registers `pend_hi` and `pend_lo`, and a `pend_valid` flag.
- **IDLE, valid start** (`start` in 001–100, `req`=0):
  - Compute the result from this cycle's operands and latch it into `pend_hi`/`pend_lo`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`; enter RUN; set `busy`.
  - Operands are not re-sampled later.
- **RUN:**
  - Decrement `cnt` each cycle.
  - When `cnt` reaches 1 in RUN, at that edge: HI←`pend_hi`, LO←`pend_lo` (if `pend_valid`), `busy`←0, go to IDLE.
- **Arithmetic:**
  - multu: {HI,LO} = zero-extended 64-bit product.
  - mult: {HI,LO} = signed 64-bit product.
  - divu: LO = unsigned quotient, HI = unsigned remainder.
  - div: LO = signed quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero (div or divu): the sequencer still runs `DIV_CYCLES` busy cycles, but `pend_valid`=0, so HI/LO are unchanged.
- **mthi/mtlo:** in IDLE with `MD_write_enable`=1 and `req`=0, the selected register ← `rs_data` at the edge.
- **Simultaneous `start` and `MD_write_enable`:** `start` wins; the write is dropped. The decoder never issues both.
- **`start` or write while busy:** ignored. The D-stage hazard logic stalls md instructions while `busy`||`start`≠0; the bench asserts this never happens.
- **Reset:** synchronous and dominant, including mid-RUN. HI=0, LO=0, `busy`=0, `cnt`=0, pending cleared, state IDLE. An in-flight result is discarded.
- **Mid-RUN `req`:** has no effect on the running op, which was already committed past E.

## Timing
- `start` is sampled at edge t. `busy` is 1 for cycles t+1 … t+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- HI/LO hold the new values from cycle t+N+1 onward, the same cycle `busy` is first 0.
- A back-to-back `start` is accepted at the edge ending cycle t+N+1 at the earliest, since `busy` must be 0 when sampled.
- mthi/mtlo at edge t are visible on `md_out` in cycle t+1.
- `md_out` changes combinationally with `MDaddress` within the same cycle.
- All outputs are 0 in the cycle after reset.

## Test plan
- **mult:** reset, then `start`=010, rs=0xFFFFFFFE (−2), rt=3. Expect `busy` high for exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
- **multu, then div:** multu 0xFFFFFFFF×0xFFFFFFFF gives HI=0xFFFFFFFE, LO=0x00000001. Then div −7/2 gives `busy` for 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Divide edge cases:** divu 7/0 with HI/LO preloaded 0x11/0x22 gives `busy` for 10 cycles, then HI=0x11, LO=0x22 unchanged. div 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- **Flush:** `start`=001 with `req`=1 gives `busy` staying 0 and HI/LO unchanged. `MD_write_enable`=1, `MDaddress`=1, `req`=1 leaves HI unchanged.
- **mthi/mtlo:** mthi 0xDEADBEEF, then mtlo 0x12345678. `md_out` reads 0xDEADBEEF with `MDaddress`=1 and 0x12345678 with `MDaddress`=0, each one cycle after the write.
- **Reset mid-run:** reset asserted in cycle 3 of a div gives `busy`=0 next cycle, HI=LO=0, and no late commit in any later cycle.
